// File: rtl/axi4_mem_responder_if.sv
// AXI4 (AXI3-style WID, 4-bit LEN) memory port bundle between a bus master and
// the memory responder.
interface axi4_mem_responder_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 32,
    parameter int BUS_LEN_WIDTH = 4,
    parameter int ID_WIDTH      = 6
);
    // Write address
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [BUS_LEN_WIDTH-1:0]  awlen;
    logic [ID_WIDTH-1:0]       awid;
    logic [1:0]                awburst;
    logic [2:0]                awsize;
    logic [1:0]                awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic [3:0]                awqos;
    // Write data
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;
    logic [ID_WIDTH-1:0]       wid;
    // Write response
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic [ID_WIDTH-1:0]       bid;
    // Read address
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [BUS_LEN_WIDTH-1:0]  arlen;
    logic [ID_WIDTH-1:0]       arid;
    logic [1:0]                arburst;
    logic [2:0]                arsize;
    logic [1:0]                arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic [3:0]                arqos;
    // Read data
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      rlast;
    logic [1:0]                rresp;
    logic [ID_WIDTH-1:0]       rid;

    modport master (
        output awvalid, awaddr, awlen, awid, awburst, awsize, awlock, awcache, awprot, awqos,
        input  awready,
        output wvalid, wdata, wstrb, wlast, wid,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arlen, arid, arburst, arsize, arlock, arcache, arprot, arqos,
        input  arready,
        input  rvalid, rdata, rlast, rresp, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awid, awburst, awsize, awlock, awcache, awprot, awqos,
        output awready,
        input  wvalid, wdata, wstrb, wlast, wid,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arlen, arid, arburst, arsize, arlock, arcache, arprot, arqos,
        output arready,
        output rvalid, rdata, rlast, rresp, rid,
        input  rready
    );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by a byte-writable word memory; independent read and write
// FSMs, one burst in flight per direction.
module axi4_mem_responder #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_LEN_WIDTH  = 4,
    parameter int ID_WIDTH       = 6,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    axi4_mem_responder_if.slave  s_memory
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = MEM_WORDS_LOG2;
    localparam int LEN_W  = BUS_LEN_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input logic fixed);
        return fixed ? idx : idx + IDX_W'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [2**IDX_W];

    // ---------------- write channel ----------------
    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic [LEN_W-1:0]      wlen_q, wlen_d;
    logic [LEN_W-1:0]      wcnt_q, wcnt_d;
    logic                  wfixed_q, wfixed_d;
    logic                  werr_q, werr_d;
    logic                  mem_we;
    logic                  wbeat_last;
    logic                  werr_beat;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        bid_d      = bid_q;
        widx_d     = widx_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        wfixed_d   = wfixed_q;
        werr_d     = werr_q;
        mem_we     = 1'b0;
        wbeat_last = (wcnt_q == wlen_q);
        werr_beat  = werr_q | (s_memory.wlast != wbeat_last);

        unique case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (s_memory.awvalid && awready_q) begin
                    widx_d    = s_memory.awaddr[OFF_W +: IDX_W];
                    wlen_d    = s_memory.awlen;
                    bid_d     = s_memory.awid;
                    wfixed_d  = (s_memory.awburst == 2'b00);
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_memory.wvalid && wready_q) begin
                    mem_we = 1'b1;
                    werr_d = werr_beat;
                    widx_d = next_idx(widx_q, wfixed_q);
                    // The beat count alone closes the burst; WLAST only feeds the error flag.
                    if (wbeat_last) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = werr_beat ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end else begin
                        wcnt_d = wcnt_q + LEN_W'(1);
                    end
                end
            end
            W_RESP: begin
                if (s_memory.bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wfixed_q  <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wfixed_q  <= wfixed_d;
            werr_q    <= werr_d;
        end
    end

    // NOTE: the memory array has no reset so it maps onto block RAM; contents survive ARESET.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_memory.wstrb[b]) mem[widx_q][b*8 +: 8] <= s_memory.wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IDX_W-1:0]      ridx_q, ridx_d;
    logic [LEN_W-1:0]      rlen_q, rlen_d;
    logic [LEN_W-1:0]      rcnt_q, rcnt_d;
    logic                  rfixed_q, rfixed_d;
    logic                  rd_en;
    logic [IDX_W-1:0]      rd_idx;
    logic [LEN_W-1:0]      rcnt_inc;

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rfixed_d  = rfixed_q;
        rd_en     = 1'b0;
        rd_idx    = '0;
        rcnt_inc  = rcnt_q + LEN_W'(1);

        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_memory.arvalid && arready_q) begin
                    ridx_d    = s_memory.araddr[OFF_W +: IDX_W];
                    rlen_d    = s_memory.arlen;
                    rid_d     = s_memory.arid;
                    rfixed_d  = (s_memory.arburst == 2'b00);
                    rcnt_d    = '0;
                    rd_en     = 1'b1;
                    rd_idx    = s_memory.araddr[OFF_W +: IDX_W];
                    rlast_d   = (s_memory.arlen == '0);
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && s_memory.rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        ridx_d  = next_idx(ridx_q, rfixed_q);
                        rd_en   = 1'b1;
                        rd_idx  = next_idx(ridx_q, rfixed_q);
                        rcnt_d  = rcnt_inc;
                        rlast_d = (rcnt_inc == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        // Memory is sampled before this edge's write lands, so a same-word read sees old data.
        rdata_d = rd_en ? mem[rd_idx] : rdata_q;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rfixed_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rfixed_q  <= rfixed_d;
        end
    end

    assign s_memory.awready = awready_q;
    assign s_memory.wready  = wready_q;
    assign s_memory.bvalid  = bvalid_q;
    assign s_memory.bresp   = bresp_q;
    assign s_memory.bid     = bid_q;
    assign s_memory.arready = arready_q;
    assign s_memory.rvalid  = rvalid_q;
    assign s_memory.rdata   = rdata_q;
    assign s_memory.rlast   = rlast_q;
    assign s_memory.rresp   = 2'b00;
    assign s_memory.rid     = rid_q;

    // Sideband fields the responder accepts but does not act on.
    logic unused_ok;
    assign unused_ok = ^{s_memory.awaddr, s_memory.araddr, s_memory.awsize, s_memory.awlock,
                         s_memory.awcache, s_memory.awprot, s_memory.awqos, s_memory.wid,
                         s_memory.arsize, s_memory.arlock, s_memory.arcache, s_memory.arprot,
                         s_memory.arqos, s_memory.awburst, s_memory.arburst};
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Self-checking bench for axi4_mem_responder: a reference memory model feeds an
// expected-data queue that is drained as read beats arrive.
module tb_axi4_mem_responder;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int LW = 4;
    localparam int IW = 6;
    localparam int ML = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUS_LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

    axi4_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUS_LEN_WIDTH(LW), .ID_WIDTH(IW), .MEM_WORDS_LOG2(ML)
    ) dut (
        .ACLK     (clk),
        .ARESET   (rst),
        .s_memory (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] model [1024];
    logic [63:0] exp_q [$];
    logic [63:0] beat_data [16];
    logic [7:0]  beat_strb [16];

    task automatic idle_bus();
        bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0; bus.awid = '0; bus.awburst = 2'b01;
        bus.awsize = 3'd3; bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0;
        bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0; bus.wid = '0;
        bus.bready = 0;
        bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.arid = '0; bus.arburst = 2'b01;
        bus.arsize = 3'd3; bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0;
        bus.rready = 0;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [5:0] id,
                            input logic [1:0] burst, input int wlast_beat,
                            output logic [1:0] bresp, output logic [5:0] bid);
        int cyc;
        logic [9:0] idx;
        bus.awvalid = 1; bus.awaddr = addr; bus.awlen = LW'(len); bus.awid = id; bus.awburst = burst;
        cyc = 0;
        while (!bus.awready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!bus.awready) begin
            checks++; errors++;
            $display("FAIL aw_handshake: awready=%0b required 1 within 50 cycles", bus.awready);
        end
        @(negedge clk);
        bus.awvalid = 0;
        idx = addr[3 +: 10];
        for (int i = 0; i <= len; i++) begin
            bus.wvalid = 1; bus.wdata = beat_data[i]; bus.wstrb = beat_strb[i];
            bus.wlast = (i == wlast_beat);
            cyc = 0;
            while (!bus.wready && cyc < 50) begin @(negedge clk); cyc++; end
            if (!bus.wready) begin
                checks++; errors++;
                $display("FAIL w_handshake beat %0d: wready=%0b required 1", i, bus.wready);
            end
            for (int b = 0; b < 8; b++)
                if (beat_strb[i][b]) model[idx][b*8 +: 8] = beat_data[i][b*8 +: 8];
            if (burst != 2'b00) idx = idx + 10'd1;
            @(negedge clk);
        end
        bus.wvalid = 0; bus.wlast = 0;
        bus.bready = 1;
        cyc = 0;
        while (!bus.bvalid && cyc < 50) begin @(negedge clk); cyc++; end
        if (!bus.bvalid) begin
            checks++; errors++;
            $display("FAIL b_handshake: bvalid=%0b required 1", bus.bvalid);
        end
        bresp = bus.bresp;
        bid   = bus.bid;
        @(negedge clk);
        bus.bready = 0;
    endtask

    task automatic push_expected(input logic [31:0] addr, input int len, input logic [1:0] burst);
        logic [9:0] idx;
        idx = addr[3 +: 10];
        for (int i = 0; i <= len; i++) begin
            exp_q.push_back(model[idx]);
            if (burst != 2'b00) idx = idx + 10'd1;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [5:0] id,
                           input logic [1:0] burst, input bit stall, input string name);
        int cyc, beats;
        bit stall_pending;
        logic [63:0] held_data, exp_data;
        logic held_last;
        bus.arvalid = 1; bus.araddr = addr; bus.arlen = LW'(len); bus.arid = id; bus.arburst = burst;
        cyc = 0;
        while (!bus.arready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!bus.arready) begin
            checks++; errors++;
            $display("FAIL %s ar_handshake: arready=%0b required 1", name, bus.arready);
        end
        @(negedge clk);
        bus.arvalid = 0;
        beats = 0; cyc = 0; stall_pending = 0;
        held_data = '0; held_last = 0;
        while (beats <= len && cyc < 100) begin
            bus.rready = stall ? (cyc % 2 == 1) : 1'b1;
            if (stall_pending) begin
                checks++;
                if ({bus.rvalid, bus.rdata, bus.rlast} !== {1'b1, held_data, held_last}) begin
                    errors++;
                    $display("FAIL %s stall_hold beat %0d: got v=%0b d=%h l=%0b required v=1 d=%h l=%0b",
                             name, beats, bus.rvalid, bus.rdata, bus.rlast, held_data, held_last);
                end
                stall_pending = 0;
            end
            if (bus.rvalid) begin
                if (bus.rready) begin
                    exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
                    checks++;
                    if (bus.rdata !== exp_data) begin
                        errors++;
                        $display("FAIL %s rdata beat %0d: got %h required %h", name, beats, bus.rdata, exp_data);
                    end
                    checks++;
                    if (bus.rlast !== (beats == len)) begin
                        errors++;
                        $display("FAIL %s rlast beat %0d: got %0b required %0b", name, beats, bus.rlast, beats == len);
                    end
                    checks++;
                    if (bus.rid !== id || bus.rresp !== 2'b00) begin
                        errors++;
                        $display("FAIL %s rid/rresp beat %0d: got %h/%b required %h/00", name, beats, bus.rid, bus.rresp, id);
                    end
                    beats++;
                end else begin
                    held_data = bus.rdata; held_last = bus.rlast; stall_pending = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.rready = 0;
        checks++;
        if (beats != len + 1 || bus.rvalid !== 1'b0 || bus.arready !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s completion: beats=%0d rvalid=%0b arready=%0b left=%0d required beats=%0d rvalid=0 arready=1 left=0",
                     name, beats, bus.rvalid, bus.arready, exp_q.size(), len + 1);
            exp_q.delete();
        end
    endtask

    task automatic fill_beats(input logic [63:0] base, input logic [63:0] step);
        for (int i = 0; i < 16; i++) begin
            beat_data[i] = base + step * 64'(i);
            beat_strb[i] = 8'hFF;
        end
    endtask

    task automatic test_reset();
        idle_bus();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: aw/w/b/ar/r/last=%b required 000000",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast});
        end
        checks++;
        if ({bus.bresp, bus.rresp, bus.bid, bus.rid} !== '0 || bus.rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: bresp=%b rresp=%b bid=%h rid=%h rdata=%h required zeros",
                     bus.bresp, bus.rresp, bus.bid, bus.rid, bus.rdata);
        end
        rst = 0;
        #1;
        checks++;
        if (bus.awready !== 1'b0 || bus.arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: awready=%0b arready=%0b required 0 0", bus.awready, bus.arready);
        end
        @(negedge clk);
        checks++;
        if (bus.awready !== 1'b1 || bus.arready !== 1'b1 || bus.wready !== 1'b0 || bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: awready=%0b arready=%0b wready=%0b bvalid=%0b rvalid=%0b required 1 1 0 0 0",
                     bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid);
        end
    endtask

    task automatic test_incr_burst();
        logic [1:0] bresp; logic [5:0] bid;
        fill_beats(64'h11, 64'h11);
        do_write(32'h100, 3, 6'd5, 2'b01, 3, bresp, bid);
        checks++;
        if (bresp !== 2'b00 || bid !== 6'd5) begin
            errors++;
            $display("FAIL incr_bresp: got bresp=%b bid=%0d required 00 5", bresp, bid);
        end
        exp_q.push_back(64'h11); exp_q.push_back(64'h22); exp_q.push_back(64'h33); exp_q.push_back(64'h44);
        do_read(32'h100, 3, 6'd9, 2'b01, 1'b0, "incr_read");
        push_expected(32'h100, 2, 2'b00);
        do_read(32'h100, 2, 6'd3, 2'b00, 1'b0, "fixed_read");
    endtask

    task automatic test_strobe();
        logic [1:0] bresp; logic [5:0] bid;
        beat_data[0] = 64'h0123_4567_89AB_CDEF; beat_strb[0] = 8'hFF;
        do_write(32'h400, 0, 6'd1, 2'b01, 0, bresp, bid);
        beat_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; beat_strb[0] = 8'h0F;
        do_write(32'h400, 0, 6'd2, 2'b01, 0, bresp, bid);
        checks++;
        if (bresp !== 2'b00 || bid !== 6'd2) begin
            errors++;
            $display("FAIL strobe_bresp: got bresp=%b bid=%0d required 00 2", bresp, bid);
        end
        exp_q.push_back(64'h0123_4567_FFFF_FFFF);
        do_read(32'h400, 0, 6'd4, 2'b01, 1'b0, "strobe_read");
    endtask

    task automatic test_wlast_error();
        logic [1:0] bresp; logic [5:0] bid;
        fill_beats(64'hA000_0000_0000_0001, 64'h0101);
        do_write(32'h500, 3, 6'd17, 2'b01, 1, bresp, bid);
        checks++;
        if (bresp !== 2'b10 || bid !== 6'd17) begin
            errors++;
            $display("FAIL wlast_error_bresp: got bresp=%b bid=%0d required 10 17", bresp, bid);
        end
        push_expected(32'h500, 3, 2'b01);
        do_read(32'h500, 3, 6'd18, 2'b01, 1'b0, "wlast_error_read");
    endtask

    task automatic test_wrap_top();
        logic [1:0] bresp; logic [5:0] bid;
        beat_data[0] = 64'hDEAD_0000_0000_03FF; beat_strb[0] = 8'hFF;
        beat_data[1] = 64'hBEEF_0000_0000_0000; beat_strb[1] = 8'hFF;
        do_write(32'h1FF8, 1, 6'd33, 2'b01, 1, bresp, bid);
        checks++;
        if (bresp !== 2'b00 || bid !== 6'd33) begin
            errors++;
            $display("FAIL wrap_bresp: got bresp=%b bid=%0d required 00 33", bresp, bid);
        end
        exp_q.push_back(64'hBEEF_0000_0000_0000);
        do_read(32'h0, 0, 6'd34, 2'b01, 1'b0, "wrap_index0");
        exp_q.push_back(64'hBEEF_0000_0000_0000);
        do_read(32'h8000_0000, 0, 6'd35, 2'b01, 1'b0, "alias_index0");
        exp_q.push_back(64'hDEAD_0000_0000_03FF); exp_q.push_back(64'hBEEF_0000_0000_0000);
        do_read(32'h1FF8, 1, 6'd36, 2'b10, 1'b0, "wrap_read");
    endtask

    task automatic test_rready_stall();
        logic [1:0] bresp; logic [5:0] bid;
        fill_beats(64'h5555_0000_0000_0000, 64'h1_0000_0001);
        do_write(32'h800, 7, 6'd40, 2'b01, 7, bresp, bid);
        checks++;
        if (bresp !== 2'b00 || bid !== 6'd40) begin
            errors++;
            $display("FAIL stall_bresp: got bresp=%b bid=%0d required 00 40", bresp, bid);
        end
        push_expected(32'h800, 7, 2'b01);
        do_read(32'h800, 7, 6'd41, 2'b01, 1'b1, "stall_read");
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] bresp; logic [5:0] bid;
        int cyc;
        bus.awvalid = 1; bus.awaddr = 32'h200; bus.awlen = 4'd3; bus.awid = 6'd7; bus.awburst = 2'b01;
        cyc = 0;
        while (!bus.awready && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        bus.awvalid = 0;
        bus.wvalid = 1; bus.wdata = 64'hCAFE_0000_0000_0001; bus.wstrb = 8'hFF; bus.wlast = 0;
        cyc = 0;
        while (!bus.wready && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        model[10'h40] = 64'hCAFE_0000_0000_0001;
        bus.wdata = 64'hCAFE_0000_0000_0002;
        rst = 1;
        #1;
        checks++;
        if (bus.wready !== 1'b0 || bus.awready !== 1'b0 || bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: wready=%0b awready=%0b bvalid=%0b required 0 0 0",
                     bus.wready, bus.awready, bus.bvalid);
        end
        @(negedge clk);
        rst = 0;
        bus.wvalid = 0;
        @(negedge clk);
        checks++;
        if (bus.awready !== 1'b1 || bus.wready !== 1'b0 || bus.arready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_idle: awready=%0b wready=%0b arready=%0b required 1 0 1",
                     bus.awready, bus.wready, bus.arready);
        end
        fill_beats(64'h7700_0000_0000_0010, 64'h10);
        do_write(32'h300, 3, 6'd8, 2'b01, 3, bresp, bid);
        checks++;
        if (bresp !== 2'b00 || bid !== 6'd8) begin
            errors++;
            $display("FAIL mid_reset_next_bresp: got bresp=%b bid=%0d required 00 8", bresp, bid);
        end
        push_expected(32'h300, 3, 2'b01);
        do_read(32'h300, 3, 6'd9, 2'b01, 1'b0, "mid_reset_next_read");
        exp_q.push_back(64'hCAFE_0000_0000_0001);
        do_read(32'h200, 0, 6'd10, 2'b01, 1'b0, "mid_reset_partial");
    endtask

    initial begin
        test_reset();
        test_incr_burst();
        test_strobe();
        test_wlast_error();
        test_wrap_top();
        test_rready_stall();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

- AXI4 (AXI3-style: WID, 4-bit LEN) slave responder with internal byte-writable word memory.
- Terminates the soc_miner memory master port, for simulation and for FPGA builds without external DDR.
- Read and write channels are independent FSMs. Single ID in flight per direction; responses carry the captured ID.

## Interface

- DATA_WIDTH, 64, data bus width in bits (multiple of 8)
- ADDR_WIDTH, 32, byte address width
- BUS_LEN_WIDTH, 4, AWLEN/ARLEN width
- ID_WIDTH, 6, transaction ID width
- MEM_WORDS_LOG2, 10, log2 of memory depth in DATA_WIDTH words

Clock and reset: one clock; reset is asynchronous and active-high.

- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  asynchronous active-high reset
- S_MEMORY_AWVALID / AWREADY  in/out  1/1  write-address handshake
- S_MEMORY_AWADDR / AWLEN / AWID  in  ADDR_WIDTH / BUS_LEN_WIDTH / ID_WIDTH  write burst start, length-1, ID
- S_MEMORY_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
- S_MEMORY_AWSIZE/AWLOCK/AWCACHE/AWPROT/AWQOS  in  3/2/4/3/4  accepted, ignored
- S_MEMORY_WVALID / WREADY  in/out  1/1  write-data handshake
- S_MEMORY_WDATA / WSTRB / WLAST / WID  in  DATA_WIDTH / DATA_WIDTH/8 / 1 / ID_WIDTH  write beat; WID ignored
- S_MEMORY_BVALID / BREADY  out/in  1/1  write-response handshake
- S_MEMORY_BRESP / BID  out  2 / ID_WIDTH  00 OKAY, 10 SLVERR; captured AWID
- S_MEMORY_ARVALID / ARREADY  in/out  1/1  read-address handshake
- S_MEMORY_ARADDR / ARLEN / ARID / ARBURST  in  ADDR_WIDTH / BUS_LEN_WIDTH / ID_WIDTH / 2  read burst; same burst rules as AW
- S_MEMORY_ARSIZE/ARLOCK/ARCACHE/ARPROT/ARQOS  in  3/2/4/3/4  accepted, ignored
- S_MEMORY_RVALID / RREADY  out/in  1/1  read-data handshake
- S_MEMORY_RDATA / RLAST / RRESP / RID  out  DATA_WIDTH / 1 / 2 / ID_WIDTH  read beat; RRESP always 00; RID = captured ARID

## Operation

- Word index = addr[log2(DATA_WIDTH/8) +: MEM_WORDS_LOG2]. Upper address bits ignored (aliasing). Low byte-offset bits ignored.
- Memory contents are not reset.
- Index advance per beat: INCR/WRAP add 1 mod 2^MEM_WORDS_LOG2 (wraps at top of memory); FIXED holds the index.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On AW handshake, capture index, AWLEN, AWID, burst; clear beat count and error flag; go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake, write bytes where WSTRB[i]=1, then advance index and count.
  - Error flag sets if WLAST differs from (count==len) on any beat.
  - Beat with count==len ends the burst: go to W_RESP. Beat count alone ends the burst; WLAST never terminates it.
  - W_RESP: BVALID=1, BRESP = error ? 10 : 00. On BREADY, go to W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. On AR handshake, capture fields and register RDATA from mem[index]; go to R_DATA.
  - R_DATA: RVALID=1; RLAST=(count==len).
  - On R handshake: if last, go to R_IDLE; else advance index and load next RDATA.
  - RDATA/RLAST remain stable while RVALID && !RREADY.
- Simultaneous read and write of the same word in one cycle: read returns pre-write data.

## Timing

- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BRESP, RRESP = 00; BID, RID, RDATA = 0. Both FSMs in IDLE.
- AWREADY and ARREADY are registered; they rise the first edge after ARESET deasserts.
- ARESET asserted mid-burst: both FSMs return to IDLE immediately. Partial writes already performed remain in memory.
- Write: AW handshake at edge n; WREADY at n+1. An N-beat burst with WVALID held high completes at n+N. BVALID at n+N+1.
- Read: AR handshake at edge n; first RVALID with valid data at n+1. Beats are back-to-back while RREADY=1.
- Next AW or AR accepted one cycle after the previous burst's B or last-R handshake. No outstanding-transaction overlap.

## Test plan

- Reset release -> AWREADY=ARREADY=1 after one edge; all other outputs at reset values.
- Write AWADDR=0x100, LEN=3, INCR, data 0x11..0x44, WLAST on beat 4, AWID=5 -> BRESP=00, BID=5. Read ARADDR=0x100, LEN=3 -> RDATA 0x11,0x22,0x33,0x44; RLAST on beat 4 only; RID matches ARID.
- WSTRB=0x0F write of 0xFFFF_FFFF_FFFF_FFFF over word 0x0123_4567_89AB_CDEF -> read returns 0x0123_4567_FFFF_FFFF.
- WLAST asserted on beat 2 of LEN=3 burst -> all 4 beats accepted; BRESP=10.
- INCR burst starting at last word (index 1023), LEN=1 -> second beat written to index 0.
- RREADY toggled 0/1 each cycle during an 8-beat read -> data and RLAST held stable while stalled; no beat lost or duplicated.
- ARESET pulsed during beat 2 of write burst -> FSMs return to IDLE; next full burst completes with OKAY.
